// File: rtl/hex_pkg.sv
// Shared constants and state type for the hex digit assembler.
package hex_pkg;

  localparam int unsigned NIB_W      = 4;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned SUM_W      = 7;
  localparam int unsigned CNT_W      = 4;

  // COLLECT: accepting digits; HOLD: presenting a finished word.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/hex_digit_assembler.sv
// Hex digit assembler: collects 8 hex digits (LS digit first) into a 32-bit
// word plus the sum of its digits, then holds them until the consumer takes it.
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   nib_in      incoming hex digit
//   nib_valid   nib_in is valid
//   nib_ready   block can accept a digit this cycle (COLLECT)
//   word_out    assembled word
//   sum_out     sum of the digits in word_out
//   word_valid  word_out/sum_out complete (HOLD)
//   word_ready  consumer accepts the word
module hex_digit_assembler
  import hex_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SUM_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NIB_W-1:0]  nib_in,
  input  logic              nib_valid,
  output logic              nib_ready,
  output logic [WORD_W-1:0] word_out,
  output logic [SUM_W-1:0]  sum_out,
  output logic              word_valid,
  input  logic              word_ready
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q,   cnt_d;
  logic [WORD_W-1:0]   shreg_q, shreg_d;
  logic [SUM_W-1:0]    acc_q,   acc_d;

  // Next-state: shift/accumulate in COLLECT, clear everything on handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    case (state_q)
      COLLECT: begin
        if (nib_valid) begin
          shreg_d = {nib_in, shreg_q[WORD_W-1:NIB_W]};
          acc_d   = acc_q + SUM_W'(nib_in);
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (word_ready) begin
          state_d = COLLECT;
          cnt_d   = '0;
          shreg_d = '0;
          acc_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // All datapath and FSM state in one register process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      shreg_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake flags decode straight from the state register.
  assign nib_ready  = (state_q == COLLECT);
  assign word_valid = (state_q == HOLD);
  assign word_out   = shreg_q;
  assign sum_out    = acc_q;

endmodule

// File: doc/hex_digit_assembler.md
HEX_DIGIT_ASSEMBLER -- requirements
Module: hex_digit_assembler

Interface
REQ-001 Parameter NUM_DIGITS, default 8: hex digits per word; only 8 is supported.
REQ-002 Parameter SUM_W, default 7: digit-sum width; max sum 8*15 = 120.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 nib_in  input  4  incoming hex digit, least-significant digit first.
REQ-006 nib_valid  input  1  nib_in holds a valid digit.
REQ-007 nib_ready  output  1  block can accept a digit this cycle.
REQ-008 word_out  output  32  assembled word.
REQ-009 sum_out  output  SUM_W  sum of the 8 digits in word_out.
REQ-010 word_valid  output  1  word_out and sum_out are complete and valid.
REQ-011 word_ready  input  1  consumer accepts word_out/sum_out.

Function
REQ-012 The FSM SHALL have exactly two states: COLLECT (nib_ready=1, word_valid=0) and HOLD (nib_ready=0, word_valid=1). Both outputs SHALL decode from registered state only.
REQ-013 A digit is accepted on a rising edge with nib_valid=1 and nib_ready=1.
REQ-014 On acceptance: shift register <= {nib_in, shreg[31:4]}; sum accumulator += nib_in (zero-extended to SUM_W); 4-bit digit counter += 1.
REQ-015 After 8 accepted digits, the first digit SHALL occupy word_out[3:0] and the eighth SHALL occupy word_out[31:28].
REQ-016 On the 8th acceptance the FSM SHALL enter HOLD. word_valid SHALL assert in the cycle after that edge, with word_out and sum_out already final (latency 1 cycle).
REQ-017 In HOLD, word_out and sum_out SHALL remain stable. nib_valid SHALL be ignored, and no digit SHALL be accepted.
REQ-018 In HOLD, an edge with word_ready=1 completes the word handshake. The next state is COLLECT with counter=0, accumulator=0 and shift register=0, and nib_ready=1 in the following cycle.
REQ-019 No same-cycle bypass: a digit SHALL never be accepted in the cycle in which word_valid=1. Minimum period is 9 cycles per word.
REQ-020 word_ready SHALL be ignored in COLLECT.
REQ-021 Gaps in nib_valid mid-word SHALL preserve partial state indefinitely, with no timeout.
REQ-022 The sum SHALL never overflow (120 < 128). No saturation logic is required.
REQ-023 word_out and sum_out SHALL be driven directly from the shift register and accumulator. Their values are defined only while word_valid=1.

Reset
REQ-024 rst=1 SHALL asynchronously force: state COLLECT, counter 0, shift register 0, accumulator 0.
REQ-025 Output reset values: word_out=0, sum_out=0, word_valid=0, nib_ready=1.
REQ-026 Reset mid-word or in HOLD SHALL discard the partial or pending word. No word_valid pulse SHALL follow.

Structure
REQ-027 The shared package hex_pkg SHALL hold:
- NIB_W=4, NUM_DIGITS=8, WORD_W=32, SUM_W=7, CNT_W=4
- the two-value state enum (COLLECT, HOLD)
REQ-028 The block SHALL be a single module with no sub-modules. Shift register, accumulator, counter and FSM live in one sequential process.

Verification
REQ-029 Reset, then feed digits 1,2,3,4,5,6,7,8 back-to-back with word_ready=1 -> word_valid=1 for one cycle, starting 1 cycle after the 8th accept; word_out=0x87654321; sum_out=36.
REQ-030 Feed eight 0xF digits -> word_out=0xFFFFFFFF, sum_out=120.
REQ-031 Feed digits with nib_valid low on alternate cycles. Hold word_ready=0 for 5 cycles in HOLD while nib_valid=1 with nib_in=0x3 -> outputs stable, nib_ready=0, no extra accept. Then word_ready=1 -> nib_ready=1 on the next cycle.
REQ-032 Accept 3 digits, pulse rst, then feed eight 0xA digits -> word_out=0xAAAAAAAA, sum_out=80, and no earlier word_valid.
REQ-033 Two consecutive words: 0..7, then 8..F, with word_ready=1 -> first word 0x76543210 sum 28; second word 0xFEDCBA98 sum 92; the first digit of the second word is accepted 1 cycle after the first handshake.
REQ-034 Assert rst while in HOLD -> word_valid=0 and nib_ready=1 immediately (asynchronous), word_out=0, sum_out=0.
